// File: rtl/loaded_counter_core.sv
// loaded_counter_core: loadable up/down counter with runtime step; define LOADED_COUNTER_SATURATE_EN for saturating arithmetic.
module loaded_counter_core #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     direction_i,
  input  logic                     load_enable_i,
  input  logic [COUNTER_WIDTH-1:0] load_data_i,
  input  logic [COUNTER_WIDTH-1:0] increment_i,
  output logic [COUNTER_WIDTH-1:0] value_o,
  output logic                     wrap_o
);
  logic [COUNTER_WIDTH-1:0] value_q, value_d, step_value;
  logic [COUNTER_WIDTH:0]   step_res;
  logic                     wrap_q, wrap_d;
  always_comb begin
    // Extra top bit holds the carry of the add or the borrow of the subtract.
    step_res = direction_i ? {1'b0, value_q} + {1'b0, increment_i}
                           : {1'b0, value_q} - {1'b0, increment_i};
`ifdef LOADED_COUNTER_SATURATE_EN
    step_value = step_res[COUNTER_WIDTH] ? (direction_i ? '1 : '0) : step_res[COUNTER_WIDTH-1:0];
`else
    step_value = step_res[COUNTER_WIDTH-1:0];
`endif
    value_d = load_enable_i ? load_data_i : enable_i ? step_value : value_q;
    wrap_d  = !load_enable_i && enable_i && step_res[COUNTER_WIDTH];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end
  assign value_o = value_q;
  assign wrap_o  = wrap_q;
endmodule

// File: tb/tb_loaded_counter_core.sv
// tb_loaded_counter_core: directed checks of reset, load, count, wrap, priority and reset mid-run.
module tb_loaded_counter_core;
  localparam int W = 8;
  logic         clk_i = 1'b0;
  logic         rst_i, enable_i, direction_i, load_enable_i;
  logic [W-1:0] load_data_i, increment_i, value_o;
  logic         wrap_o;
  int           total = 0;
  int           bad = 0;

  loaded_counter_core #(.COUNTER_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .direction_i(direction_i),
    .load_enable_i(load_enable_i), .load_data_i(load_data_i), .increment_i(increment_i),
    .value_o(value_o), .wrap_o(wrap_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] d);
    load_enable_i = 1'b1;
    load_data_i = d;
    enable_i = 1'b0;
    tick();
    load_enable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; direction_i = 1'b1; load_enable_i = 1'b0;
    load_data_i = '0; increment_i = '0;
    #3 rst_i = 1'b0;
    do_load(8'h55);
    total++;
    if (value_o !== 8'h55) begin bad++; $display("FAIL reset_preload value got=%h want=55", value_o); end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (value_o !== 8'h00 || wrap_o !== 1'b0) begin
      bad++; $display("FAIL reset_async value=%h wrap=%b want 00/0", value_o, wrap_o);
    end
    load_enable_i = 1'b1; load_data_i = 8'h33;
    tick();
    load_enable_i = 1'b0;
    total++;
    if (value_o !== 8'h00) begin bad++; $display("FAIL reset_hold value got=%h want=00", value_o); end
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (value_o !== 8'h00 || wrap_o !== 1'b0) begin
        bad++; $display("FAIL reset_idle[%0d] value=%h wrap=%b want 00/0", i, value_o, wrap_o);
      end
    end
  endtask

  task automatic test_load_count_up();
    logic [W-1:0] exp;
    do_load(8'h10);
    total++;
    if (value_o !== 8'h10) begin bad++; $display("FAIL load value got=%h want=10", value_o); end
    increment_i = 8'd3; direction_i = 1'b1; enable_i = 1'b1;
    exp = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = exp + 8'd3;
      total++;
      if (value_o !== exp || wrap_o !== 1'b0) begin
        bad++; $display("FAIL count_up[%0d] value=%h wrap=%b want %h/0", i, value_o, wrap_o, exp);
      end
    end
    enable_i = 1'b0;
    tick();
    total++;
    if (value_o !== 8'h1C) begin bad++; $display("FAIL freeze value got=%h want=1c", value_o); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_dn, exp_up;
`ifdef LOADED_COUNTER_SATURATE_EN
    exp_dn = 8'h00; exp_up = 8'hFF;
`else
    exp_dn = 8'hFD; exp_up = 8'h01;
`endif
    do_load(8'h02);
    increment_i = 8'd5; direction_i = 1'b0; enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    total++;
    if (value_o !== exp_dn || wrap_o !== 1'b1) begin
      bad++; $display("FAIL wrap_down value=%h wrap=%b want %h/1", value_o, wrap_o, exp_dn);
    end
    tick();
    total++;
    if (value_o !== exp_dn || wrap_o !== 1'b0) begin
      bad++; $display("FAIL wrap_pulse value=%h wrap=%b want %h/0", value_o, wrap_o, exp_dn);
    end
    do_load(8'hFE);
    increment_i = 8'd3; direction_i = 1'b1; enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    total++;
    if (value_o !== exp_up || wrap_o !== 1'b1) begin
      bad++; $display("FAIL wrap_up value=%h wrap=%b want %h/1", value_o, wrap_o, exp_up);
    end
    do_load(8'h05);
    increment_i = 8'd5; direction_i = 1'b0; enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    total++;
    if (value_o !== 8'h00 || wrap_o !== 1'b0) begin
      bad++; $display("FAIL down_to_zero value=%h wrap=%b want 00/0", value_o, wrap_o);
    end
  endtask

  task automatic test_load_priority();
    do_load(8'h40);
    load_enable_i = 1'b1; load_data_i = 8'hAA; enable_i = 1'b1;
    increment_i = 8'd1; direction_i = 1'b1;
    tick();
    load_enable_i = 1'b0;
    total++;
    if (value_o !== 8'hAA || wrap_o !== 1'b0) begin
      bad++; $display("FAIL load_priority value=%h wrap=%b want aa/0", value_o, wrap_o);
    end
    tick();
    enable_i = 1'b0;
    total++;
    if (value_o !== 8'hAB) begin bad++; $display("FAIL after_priority value got=%h want=ab", value_o); end
  endtask

  task automatic test_zero_inc();
    do_load(8'hFF);
    increment_i = 8'd0; direction_i = 1'b1; enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
    total++;
    if (value_o !== 8'hFF || wrap_o !== 1'b0) begin
      bad++; $display("FAIL zero_inc value=%h wrap=%b want ff/0", value_o, wrap_o);
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(8'h7C);
    increment_i = 8'd1; direction_i = 1'b1; enable_i = 1'b1;
    repeat (3) tick();
    total++;
    if (value_o !== 8'h7F) begin bad++; $display("FAIL mid_run_pre value got=%h want=7f", value_o); end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (value_o !== 8'h00 || wrap_o !== 1'b0) begin
      bad++; $display("FAIL mid_run_reset value=%h wrap=%b want 00/0", value_o, wrap_o);
    end
    #1 rst_i = 1'b0;
    tick();
    total++;
    if (value_o !== 8'h01) begin bad++; $display("FAIL mid_run_resume value got=%h want=01", value_o); end
    enable_i = 1'b0;
  endtask

  task automatic test_random();
    int m, e, inc;
    logic exp_wrap;
    for (int s = 0; s < 20; s++) begin
      m = $urandom_range(0, 255);
      do_load(m[W-1:0]);
      for (int k = 0; k < 50; k++) begin
        inc = $urandom_range(0, 7);
        direction_i = 1'($urandom_range(0, 1));
        increment_i = inc[W-1:0];
        enable_i = 1'b1;
        e = direction_i ? m + inc : m - inc;
        exp_wrap = (e > 255) || (e < 0);
`ifdef LOADED_COUNTER_SATURATE_EN
        m = e > 255 ? 255 : e < 0 ? 0 : e;
`else
        m = (e + 256) % 256;
`endif
        tick();
        total++;
        if (value_o !== m[W-1:0] || wrap_o !== exp_wrap) begin
          bad++; $display("FAIL random[%0d.%0d] value=%h wrap=%b want %h/%b", s, k, value_o, wrap_o, m[W-1:0], exp_wrap);
        end
      end
      enable_i = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_load_count_up();
    test_wrap();
    test_load_priority();
    test_zero_inc();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
